fetch_unit: RTL

Instruction-fetch front end of the sequential RV64 core. It owns the PC register, issues word fetches to instruction memory, and presents one instruction at a time to decode over a valid/ready handshake. It consumes the execute stage's branch_taken/branch_target redirect, which aborts any in-flight fetch and restarts fetching at the target.

---
 rtl/fetch_unit_pkg.sv | 6 +
 rtl/fetch_unit.sv | 80 ++++++++
 2 files changed

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared fetch state encoding and fetch constants
package fetch_unit_pkg;
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_FAULT} fetch_state_e;
  localparam int INSTR_BYTES = 4;
  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;
endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: PC-owning instruction fetch front end with redirect, drop and misalignment fault
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int XLEN = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr,
  input  logic            if_ready,
  output logic            fetch_fault
);
  fetch_state_e state, state_n;
  logic [XLEN-1:0] pc_q, pc_n, inflight_pc;
  logic drop, drop_n, capture, misaligned;
  assign misaligned = branch_taken && (branch_target[1:0] != 2'b00) && (state != S_FAULT);
  assign imem_req_valid = (state == S_REQ) && !reset;
  assign imem_req_addr = pc_q;
  assign if_valid = (state == S_HOLD);
  always_comb begin
    state_n = state;
    pc_n = pc_q;
    drop_n = drop;
    capture = 1'b0;
    case (state)
      S_REQ: begin
        pc_n = branch_taken ? branch_target : imem_req_ready ? pc_q + XLEN'(INSTR_BYTES) : pc_q;
        state_n = imem_req_ready ? S_WAIT : S_REQ;
        drop_n = branch_taken && imem_req_ready;
      end
      S_WAIT: begin
        pc_n = branch_taken ? branch_target : pc_q;
        state_n = imem_rsp_valid ? ((branch_taken || drop) ? S_REQ : S_HOLD) : S_WAIT;
        drop_n = imem_rsp_valid ? 1'b0 : (drop || branch_taken);
        capture = imem_rsp_valid && !branch_taken && !drop;
      end
      S_HOLD: begin
        pc_n = branch_taken ? branch_target : pc_q;
        state_n = (branch_taken || if_ready) ? S_REQ : S_HOLD;
      end
      default: ;
    endcase
    if (misaligned) begin
      state_n = S_FAULT;
      drop_n = 1'b0;
      capture = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_REQ;
      pc_q <= RESET_PC;
      drop <= 1'b0;
      inflight_pc <= '0;
      if_pc <= '0;
      if_instr <= '0;
      fetch_fault <= 1'b0;
    end else begin
      state <= state_n;
      pc_q <= pc_n;
      drop <= drop_n;
      if (state == S_REQ && imem_req_ready) inflight_pc <= pc_q;
      if (capture) begin
        if_pc <= inflight_pc;
        if_instr <= imem_rsp_data;
      end
      if (misaligned) fetch_fault <= 1'b1;
    end
  end
endmodule
